// File: rtl/vc_wrr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vc_arb_pkg
//   Shared types and helpers for the virtual-channel weighted round-robin
//   arbiter: FSM state encoding, default sizing, and the rotate-priority
//   first-set search used by the request picker.
// ---------------------------------------------------------------------------
package vc_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int unsigned DEF_NUM_VC = 4;
    localparam int unsigned DEF_WGT_W  = 4;

    // Upper bound on channel count supported by the search helper.
    localparam int unsigned MAX_VC    = 32;
    localparam int unsigned MAX_IDX_W = 5;

    // Returns the first set bit of req[n-1:0] scanning ptr, ptr+1, ...
    // wrapping modulo n, or -1 when no bit is set.
    function automatic int rr_first_set(input logic [MAX_VC-1:0] req,
                                        input int unsigned       n,
                                        input int unsigned       ptr);
        int          result;
        int unsigned idx;
        result = -1;
        for (int unsigned k = 0; k < n; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (result < 0 && req[idx[MAX_IDX_W-1:0]]) begin
                result = int'(idx);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/vc_wrr_arbiter_if.sv
// ---------------------------------------------------------------------------
// vc_wrr_arbiter_if
//   Bundle between the VC FIFOs / downstream stage and the arbiter.
//     enb         arbitration enable
//     empty_vc    FIFO empty flags, bit i = VC i
//     weight_cfg  per-VC burst quota, slice i = [i*WGT_W +: WGT_W]
//     out_ready   downstream accepts one word this cycle
//     pop_vc      one-hot FIFO pop strobe (combinational)
//     grant_vc    one-hot registered grant
//     grant_idx   binary index of granted VC (output mux select)
//     grant_valid grant_vc / grant_idx meaningful
//   master: arbiter side (drives pops and grants)
//   slave : FIFO / downstream side
// ---------------------------------------------------------------------------
interface vc_wrr_arbiter_if
    import vc_arb_pkg::*;
#(
    parameter int unsigned NUM_VC = DEF_NUM_VC,
    parameter int unsigned VC_W   = $clog2(NUM_VC),
    parameter int unsigned WGT_W  = DEF_WGT_W
);

    logic                    enb;
    logic [NUM_VC-1:0]       empty_vc;
    logic [NUM_VC*WGT_W-1:0] weight_cfg;
    logic                    out_ready;
    logic [NUM_VC-1:0]       pop_vc;
    logic [NUM_VC-1:0]       grant_vc;
    logic [VC_W-1:0]         grant_idx;
    logic                    grant_valid;

    modport master (
        input  enb,
        input  empty_vc,
        input  weight_cfg,
        input  out_ready,
        output pop_vc,
        output grant_vc,
        output grant_idx,
        output grant_valid
    );

    modport slave (
        output enb,
        output empty_vc,
        output weight_cfg,
        output out_ready,
        input  pop_vc,
        input  grant_vc,
        input  grant_idx,
        input  grant_valid
    );

endinterface

// File: rtl/vc_wrr_arbiter_picker.sv
// ---------------------------------------------------------------------------
// vc_rr_picker
//   Combinational rotate-priority picker: finds the first set request bit
//   starting at rr_ptr and wrapping modulo NUM_VC.
//     req    in  NUM_VC  request vector (bit i = VC i wants service)
//     rr_ptr in  VC_W    highest-priority index this cycle
//     sel    out VC_W    selected index (0 when nothing found)
//     found  out 1       at least one request bit set
// ---------------------------------------------------------------------------
module vc_rr_picker
    import vc_arb_pkg::*;
#(
    parameter int unsigned NUM_VC = DEF_NUM_VC,
    parameter int unsigned VC_W   = $clog2(NUM_VC)
) (
    input  logic [NUM_VC-1:0] req,
    input  logic [VC_W-1:0]   rr_ptr,
    output logic [VC_W-1:0]   sel,
    output logic              found
);

    logic [MAX_VC-1:0] req_ext;
    int                hit;

    always_comb begin
        req_ext             = '0;
        req_ext[NUM_VC-1:0] = req;
        hit                 = rr_first_set(req_ext, NUM_VC, 32'(rr_ptr));
        found               = (hit >= 0);
        sel                 = found ? VC_W'(hit) : '0;
    end

endmodule

// File: rtl/vc_wrr_arbiter.sv
// ---------------------------------------------------------------------------
// vc_wrr_arbiter
//   Weighted round-robin arbiter for the virtual-channel egress path.
//   Grants one VC at a time for a burst of up to weight_cfg[vc] pops
//   (a zero weight counts as one), drives the FIFO pop strobe gated by
//   out_ready, and rotates priority past the last served VC.
//   Ports:
//     clk  in  clock, all state on rising edge
//     rst  in  asynchronous, active-low reset
//     arb  master modport of vc_wrr_arbiter_if (enb, empty_vc, weight_cfg,
//          out_ready in; pop_vc, grant_vc, grant_idx, grant_valid out)
//   Build option:
//     VC_WRR_FAST_SWITCH_EN  when defined, a burst that ends with enb high
//       and another VC non-empty hands over to the next VC on the same
//       edge (no IDLE bubble). Undefined: one IDLE cycle between grants.
// ---------------------------------------------------------------------------
module vc_wrr_arbiter
    import vc_arb_pkg::*;
#(
    parameter int unsigned NUM_VC = DEF_NUM_VC,
    parameter int unsigned VC_W   = $clog2(NUM_VC),
    parameter int unsigned WGT_W  = DEF_WGT_W
) (
    input  logic             clk,
    input  logic             rst,
    vc_wrr_arbiter_if.master arb
);

    state_t            state, state_nxt;
    logic [VC_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [VC_W-1:0]   grant_idx_q, grant_idx_nxt;
    logic [NUM_VC-1:0] grant_vc_q, grant_vc_nxt;
    logic              grant_valid_q, grant_valid_nxt;
    logic [WGT_W-1:0]  credit_q, credit_nxt;

    logic [NUM_VC-1:0] req;
    logic [VC_W-1:0]   idle_sel;
    logic              idle_found;
    logic [VC_W-1:0]   adv_ptr;
    logic              cur_empty;
    logic              pop;
    logic              leave;
    logic [NUM_VC-1:0] pop_vc;

    // Burst quota for a channel; a zero weight still allows one pop.
    function automatic logic [WGT_W-1:0] quota_of(
        input logic [NUM_VC*WGT_W-1:0] cfg,
        input logic [VC_W-1:0]         s
    );
        logic [WGT_W-1:0] w;
        w = '0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            if (VC_W'(i) == s) begin
                w = cfg[i*WGT_W +: WGT_W];
            end
        end
        return (w == '0) ? WGT_W'(1) : w;
    endfunction

    assign req = ~arb.empty_vc;

    vc_rr_picker #(
        .NUM_VC (NUM_VC),
        .VC_W   (VC_W)
    ) u_idle_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .sel    (idle_sel),
        .found  (idle_found)
    );

`ifdef VC_WRR_FAST_SWITCH_EN
    logic [VC_W-1:0] fast_sel;
    logic            fast_found;

    // Current VC is masked out so a hand-over only happens to another VC;
    // a lone backlogged VC goes through IDLE to be re-granted.
    vc_rr_picker #(
        .NUM_VC (NUM_VC),
        .VC_W   (VC_W)
    ) u_fast_pick (
        .req    (req & ~grant_vc_q),
        .rr_ptr (adv_ptr),
        .sel    (fast_sel),
        .found  (fast_found)
    );
`endif

    assign adv_ptr   = (grant_idx_q == VC_W'(NUM_VC - 1)) ? '0 : grant_idx_q + 1'b1;
    assign cur_empty = arb.empty_vc[grant_idx_q];

    always_comb begin
        state_nxt       = state;
        rr_ptr_nxt      = rr_ptr;
        grant_idx_nxt   = grant_idx_q;
        grant_vc_nxt    = grant_vc_q;
        grant_valid_nxt = grant_valid_q;
        credit_nxt      = credit_q;
        pop             = 1'b0;
        leave           = 1'b0;
        pop_vc          = '0;

        case (state)
            IDLE: begin
                if (arb.enb && idle_found) begin
                    grant_idx_nxt          = idle_sel;
                    grant_vc_nxt           = '0;
                    grant_vc_nxt[idle_sel] = 1'b1;
                    grant_valid_nxt        = 1'b1;
                    credit_nxt             = quota_of(arb.weight_cfg, idle_sel);
                    state_nxt              = BURST;
                end
            end

            BURST: begin
                pop = arb.enb && arb.out_ready && !cur_empty;
                // grant_vc_q is one-hot, so the strobe can never carry >1 bit.
                if (pop) begin
                    pop_vc     = grant_vc_q;
                    credit_nxt = credit_q - 1'b1;
                end
                leave = (pop && credit_q == WGT_W'(1)) || cur_empty || !arb.enb;
                if (leave) begin
                    rr_ptr_nxt      = adv_ptr;
                    grant_vc_nxt    = '0;
                    grant_valid_nxt = 1'b0;
                    credit_nxt      = '0;
                    state_nxt       = IDLE;
`ifdef VC_WRR_FAST_SWITCH_EN
                    if (arb.enb && fast_found) begin
                        grant_idx_nxt          = fast_sel;
                        grant_vc_nxt[fast_sel] = 1'b1;
                        grant_valid_nxt        = 1'b1;
                        credit_nxt             = quota_of(arb.weight_cfg, fast_sel);
                        state_nxt              = BURST;
                    end
`endif
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant_idx_q   <= '0;
            grant_vc_q    <= '0;
            grant_valid_q <= 1'b0;
            credit_q      <= '0;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_ptr_nxt;
            grant_idx_q   <= grant_idx_nxt;
            grant_vc_q    <= grant_vc_nxt;
            grant_valid_q <= grant_valid_nxt;
            credit_q      <= credit_nxt;
        end
    end

    assign arb.pop_vc      = pop_vc;
    assign arb.grant_vc    = grant_vc_q;
    assign arb.grant_idx   = grant_idx_q;
    assign arb.grant_valid = grant_valid_q;

endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vc_wrr_arbiter
//   Directed bench for vc_wrr_arbiter (NUM_VC=4, WGT_W=4). Expected values
//   are hand-derived cycle by cycle. Inputs are driven 1 time unit after the
//   rising edge; outputs are checked 2 units after the edge.
// ---------------------------------------------------------------------------
module tb_vc_wrr_arbiter;

    localparam int unsigned NV = 4;
    localparam int unsigned WW = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vc_wrr_arbiter_if #(.NUM_VC(NV), .WGT_W(WW)) arb_if ();

    vc_wrr_arbiter #(
        .NUM_VC (NV),
        .WGT_W  (WW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Expected pop strobe per cycle for weights {VC3..VC0} = {1,3,2,1}.
    logic [3:0] exp_t2 [13] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4,
                                4'h4, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst                = 1'b0;
        arb_if.enb         = 1'b0;
        arb_if.empty_vc    = '1;
        arb_if.out_ready   = 1'b0;
        arb_if.weight_cfg  = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_pop",   32'(arb_if.pop_vc),      32'h0);
        chk("rst_gv",    32'(arb_if.grant_valid), 32'h0);
        chk("rst_gvc",   32'(arb_if.grant_vc),    32'h0);
        chk("rst_gidx",  32'(arb_if.grant_idx),   32'h0);

        // Test 1: async reset mid-burst, then first grant back to VC0
        arb_if.weight_cfg = 16'h0003;
        arb_if.empty_vc   = 4'b0000;
        arb_if.enb        = 1'b1;
        arb_if.out_ready  = 1'b1;
        settle();
        chk("t1_idle_pop", 32'(arb_if.pop_vc), 32'h0);
        tick();
        chk("t1_pop",  32'(arb_if.pop_vc),   32'h1);
        chk("t1_gvc",  32'(arb_if.grant_vc), 32'h1);
        rst = 1'b0;
        settle();
        chk("t1_rst_pop",  32'(arb_if.pop_vc),      32'h0);
        chk("t1_rst_gv",   32'(arb_if.grant_valid), 32'h0);
        chk("t1_rst_gvc",  32'(arb_if.grant_vc),    32'h0);
        chk("t1_rst_gidx", 32'(arb_if.grant_idx),   32'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("t1_regrant_gidx", 32'(arb_if.grant_idx),   32'h0);
        chk("t1_regrant_gvc",  32'(arb_if.grant_vc),    32'h1);
        chk("t1_regrant_gv",   32'(arb_if.grant_valid), 32'h1);

`ifndef VC_WRR_FAST_SWITCH_EN
        // Test 2: all backlogged, weights VC0..VC3 = 1,2,3,1
        do_reset();
        arb_if.weight_cfg = 16'h1321;
        arb_if.empty_vc   = 4'b0000;
        arb_if.enb        = 1'b1;
        arb_if.out_ready  = 1'b1;
        for (int c = 0; c < 13; c++) begin
            settle();
            chk($sformatf("t2_pop_c%0d", c), 32'(arb_if.pop_vc), 32'(exp_t2[c]));
            chk($sformatf("t2_gv_c%0d", c),  32'(arb_if.grant_valid), 32'(exp_t2[c] != 4'h0));
            tick();
        end

        // Test 3: only VC2 backlogged, wrap scan from rr_ptr=3
        do_reset();
        arb_if.weight_cfg = 16'h1111;
        arb_if.empty_vc   = 4'b1011;
        arb_if.enb        = 1'b1;
        arb_if.out_ready  = 1'b1;
        settle();
        chk("t3_c0_pop", 32'(arb_if.pop_vc), 32'h0);
        tick();
        settle();
        chk("t3_c1_pop",  32'(arb_if.pop_vc),    32'h4);
        chk("t3_c1_gidx", 32'(arb_if.grant_idx), 32'h2);
        tick();
        settle();
        chk("t3_c2_gv", 32'(arb_if.grant_valid), 32'h0);
        tick();
        settle();
        chk("t3_wrap_gidx", 32'(arb_if.grant_idx), 32'h2);
        chk("t3_wrap_pop",  32'(arb_if.pop_vc),    32'h4);
        tick();
        arb_if.empty_vc = 4'b0011;
        settle();
        tick();
        settle();
        chk("t3_ptr3_gidx", 32'(arb_if.grant_idx), 32'h3);
        chk("t3_ptr3_pop",  32'(arb_if.pop_vc),    32'h8);

        // Test 4: out_ready toggling during a weight-4 burst on VC1
        do_reset();
        arb_if.weight_cfg = 16'h0040;
        arb_if.empty_vc   = 4'b1101;
        arb_if.enb        = 1'b1;
        arb_if.out_ready  = 1'b0;
        settle();
        tick();
        for (int c = 1; c < 8; c++) begin
            arb_if.out_ready = (c % 2 == 1);
            settle();
            chk($sformatf("t4_pop_c%0d", c), 32'(arb_if.pop_vc), (c % 2 == 1) ? 32'h2 : 32'h0);
            chk($sformatf("t4_gv_c%0d", c),  32'(arb_if.grant_valid), 32'h1);
            tick();
        end
        arb_if.out_ready = 1'b1;
        settle();
        chk("t4_done_gv",  32'(arb_if.grant_valid), 32'h0);
        chk("t4_done_pop", 32'(arb_if.pop_vc),      32'h0);

        // Test 5: VC0 empties after 1 of 3 pops
        do_reset();
        arb_if.weight_cfg = 16'h1113;
        arb_if.empty_vc   = 4'b0000;
        arb_if.enb        = 1'b1;
        arb_if.out_ready  = 1'b1;
        settle();
        tick();
        settle();
        chk("t5_first_pop", 32'(arb_if.pop_vc), 32'h1);
        tick();
        arb_if.empty_vc = 4'b0001;
        settle();
        chk("t5_empty_pop", 32'(arb_if.pop_vc),      32'h0);
        chk("t5_empty_gv",  32'(arb_if.grant_valid), 32'h1);
        tick();
        settle();
        chk("t5_idle_gv", 32'(arb_if.grant_valid), 32'h0);
        tick();
        settle();
        chk("t5_next_gidx", 32'(arb_if.grant_idx), 32'h1);
        chk("t5_next_pop",  32'(arb_if.pop_vc),    32'h2);
`else
        // Test 6: zero-bubble hand-over, all backlogged, weights all 1
        do_reset();
        arb_if.weight_cfg = 16'h1111;
        arb_if.empty_vc   = 4'b0000;
        arb_if.enb        = 1'b1;
        arb_if.out_ready  = 1'b1;
        settle();
        tick();
        for (int c = 1; c < 9; c++) begin
            settle();
            chk($sformatf("t6_pop_c%0d", c), 32'(arb_if.pop_vc), 32'(1) << ((c - 1) % 4));
            chk($sformatf("t6_gv_c%0d", c),  32'(arb_if.grant_valid), 32'h1);
            tick();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
